// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//  Shared definitions for the BCD arithmetic blocks.
//  Contents:
//   state_t        controller state encoding {IDLE, RUN, DONE}, 2 bits
//   BCD_MAX        largest legal BCD digit (9)
//   BCD_CORR       decimal correction added when a binary digit sum exceeds 9
//   is_bcd(digit)  1 when the 4-bit digit is a legal BCD value
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
//  Combinational single-digit BCD adder: o_s/o_cout = i_a + i_b + i_cin.
//  Ports:
//   i_a    in  [3:0]  addend digit
//   i_b    in  [3:0]  addend digit (already complemented by the caller in sub)
//   i_cin  in  1      carry in
//   o_s    out [3:0]  corrected BCD digit
//   o_cout out 1      decimal carry out
//  Illegal input digits go through the same +6 rule, so the result is
//  deterministic even though it is not meaningful.
// ---------------------------------------------------------------------------
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);

    logic [4:0] w_t;

    assign w_t    = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    assign o_cout = (w_t > {1'b0, BCD_MAX});
    // The correction wraps modulo 16, which is exactly (t+6)[3:0].
    assign o_s    = o_cout ? (w_t[3:0] + BCD_CORR) : w_t[3:0];

endmodule

// File: rtl/bcd_serial_addsub.sv
// ---------------------------------------------------------------------------
// bcd_serial_addsub
//  Digit-serial N-digit BCD adder/subtractor, one digit per clock, LSD first.
//  Subtraction adds the 9's complement of B with an inverted borrow, giving a
//  10's-complement difference; cout=1 then means "no borrow".
//  Ports:
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset
//   start    in   1          request, honoured only in IDLE or DONE
//   sub      in   1          0: a+b+cin, 1: a-b-cin
//   a, b     in   4*DIGITS   packed BCD operands, digit0 in [3:0]
//   cin      in   1          carry-in / borrow-in
//   busy     out  1          digits being processed
//   done     out  1          one-cycle result-valid pulse
//   sum      out  4*DIGITS   packed BCD result, held until next accept
//   cout     out  1          decimal carry / not-borrow
//   invalid  out  1          a latched operand digit was above 9
// ---------------------------------------------------------------------------
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_sub;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_sum;
    logic               r_busy;
    logic               r_done;
    logic               r_cout;
    logic               r_invalid;

    logic [DIGITS-1:0]  w_dig_bad;
    logic               w_any_bad;
    logic [3:0]         w_b_k;
    logic [3:0]         w_digit;
    logic               w_dcout;
    logic               w_accept;
    logic               w_last;

    // Per-digit legality check on the live operands, used only at accept.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign w_dig_bad[gi] = !is_bcd(a[4*gi +: 4]) || !is_bcd(b[4*gi +: 4]);
        end
    endgenerate
    assign w_any_bad = |w_dig_bad;

    // Operands are shifted right each digit, so the current digit is always [3:0].
    assign w_b_k = r_sub ? (BCD_MAX - r_b[3:0]) : r_b[3:0];

    bcd_digit_add u_digit (
        .i_a    (r_a[3:0]),
        .i_b    (w_b_k),
        .i_cin  (r_carry),
        .o_s    (w_digit),
        .o_cout (w_dcout)
    );

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == CNT_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cout    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (r_cnt == CNT_W'(k)) begin
                            r_sum[4*k +: 4] <= w_digit;
                        end
                    end
                    r_carry <= w_dcout;
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_dcout;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE falls back
                    // to IDLE when nothing is pending.
                    if (w_accept) begin
                        r_state   <= RUN;
                        r_a       <= a;
                        r_b       <= b;
                        r_sub     <= sub;
                        r_carry   <= sub ? ~cin : cin;
                        r_cnt     <= '0;
                        r_sum     <= '0;
                        r_cout    <= 1'b0;
                        r_invalid <= w_any_bad;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_addsub
//  Directed vectors with hand-computed results. The driver pushes the expected
//  result of every accepted operation into a queue; the monitor pops one entry
//  for each done pulse and compares sum/cout/invalid.
// ---------------------------------------------------------------------------
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         invalid;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one transaction line per done pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn: sum=%h cout=%b invalid=%b (exp %h %b %b)",
                         sum, cout, invalid, e.sum, e.cout, e.invalid);
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("invalid", 32'(invalid), 32'(e.invalid));
            end
        end
    end

    task automatic set_in(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic ts, input logic tc);
        a   = ta;
        b   = tb_;
        sub = ts;
        cin = tc;
    endtask

    // Full operation: checks latency to done and number of busy cycles.
    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic ei);
        int n;
        int nbusy;
        @(negedge clk);
        set_in(ta, tb_, ts, tc);
        start = 1'b1;
        exp_q.push_back('{sum: es, cout: ec, invalid: ei});
        n = 0;
        nbusy = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (busy) nbusy++;
            if (done) break;
        end
        check({name, "_latency"}, 32'(n), 32'(DIGITS + 1));
        check({name, "_busy_cycles"}, 32'(nbusy), 32'(DIGITS));
    endtask

    initial begin
        int n;
        int first_done;
        int second_done;
        int ndone;

        rst_n = 1'b0;
        start = 1'b0;
        set_in('0, '0, 1'b0, 1'b0);
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1..4: directed arithmetic
        do_op("add9999", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add0357", 16'h0357, 16'h0468, 1'b0, 1'b1, 16'h0826, 1'b0, 1'b0);
        do_op("sub1000", 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0999, 1'b1, 1'b0);
        do_op("sub0001", 16'h0001, 16'h0002, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0);
        do_op("inv00A0", 16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
        do_op("valid0", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        do_op("sub4321", 16'h4321, 16'h1234, 1'b1, 1'b1, 16'h3086, 1'b1, 1'b0);

        // 5a: start re-pulsed mid-RUN with other operands -> ignored
        @(negedge clk);
        set_in(16'h1111, 16'h2222, 1'b0, 1'b0);
        start = 1'b1;
        exp_q.push_back('{sum: 16'h3333, cout: 1'b0, invalid: 1'b0});
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            start = (n == 2);
            if (n == 2) set_in(16'h9999, 16'h9999, 1'b1, 1'b1);
            if (done) break;
        end
        check("ignore_start_latency", 32'(n), 32'(DIGITS + 1));

        // 5b: start held through DONE -> back-to-back ops, operands changed mid-RUN
        repeat (2) @(negedge clk);
        set_in(16'h0045, 16'h0055, 1'b0, 1'b0);
        start = 1'b1;
        exp_q.push_back('{sum: 16'h0100, cout: 1'b0, invalid: 1'b0});
        exp_q.push_back('{sum: 16'h0000, cout: 1'b1, invalid: 1'b0});
        first_done = 0;
        second_done = 0;
        ndone = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) set_in(16'h5000, 16'h5000, 1'b0, 1'b0);
            if (i == 6) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = i;
                if (ndone == 2) second_done = i;
            end
        end
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_first_done", 32'(first_done), 32'(DIGITS + 1));
        check("b2b_second_done", 32'(second_done), 32'(2 * (DIGITS + 1)));

        // 6: reset during the second RUN cycle
        @(negedge clk);
        set_in(16'h1234, 16'h5A78, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_abort", 32'(ndone), 32'd0);
        do_op("after_reset", 16'h0357, 16'h0468, 1'b0, 1'b1, 16'h0826, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
